// File: rtl/sumador_secuencial.sv
// Sequential adder/subtractor: K bits of a +/- b per clock, N/K cycles per operation.
// Result, carry out and two's-complement overflow are registered and held between operations.
module sumador_secuencial #(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ovf,
    output logic         busy,
    output logic         done
);

    localparam int STEPS = N / K;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUMA = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_s;
    logic          r_cout;
    logic          r_ovf;

    logic [K:0]    w_sum;
    logic [N-1:0]  w_acc_next;
    logic          w_last;
    logic          w_load;
    logic          w_carry_msb;

    assign w_sum  = {1'b0, r_a[K-1:0]} + {1'b0, r_b[K-1:0]} + {{K{1'b0}}, r_carry};
    assign w_last = (r_cnt == CW'(STEPS - 1));
    assign w_load = start && ((r_state == IDLE) || (r_state == FIN));

    // Carry into the chunk's top bit, recovered from its sum bit and operand bits.
    assign w_carry_msb = w_sum[K-1] ^ r_a[K-1] ^ r_b[K-1];

    generate
        if (K == N) begin : g_single
            assign w_acc_next = w_sum[K-1:0];
        end else begin : g_multi
            logic [N-K-1:0] r_acc;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_acc <= '0;
                end else if (r_state == SUMA) begin
                    r_acc <= w_acc_next[N-1:K];
                end
            end

            assign w_acc_next = {w_sum[K-1:0], r_acc};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) r_state <= SUMA;
                SUMA:    if (w_last) r_state <= FIN;
                FIN:     r_state <= start ? SUMA : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operands are captured only when a new operation is accepted; result registers load on the last chunk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a     <= a;
            r_b     <= b ^ {N{sub}};
            r_carry <= sub ? 1'b1 : c_in;
            r_cnt   <= '0;
        end else if (r_state == SUMA) begin
            r_a     <= r_a >> K;
            r_b     <= r_b >> K;
            r_carry <= w_sum[K];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_s    <= w_acc_next;
                r_cout <= w_sum[K];
                r_ovf  <= w_carry_msb ^ w_sum[K];
            end
        end
    end

    assign s     = r_s;
    assign c_out = r_cout;
    assign ovf   = r_ovf;
    assign busy  = (r_state == SUMA);
    assign done  = (r_state == FIN);

endmodule

// File: tb/tb_sumador_secuencial.sv
// Directed self-checking bench for sumador_secuencial: N=8/K=2 instance plus an N=4/K=4 instance.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sumador_secuencial;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cIn;
    logic       sub;
    logic [7:0] s;
    logic       cOut;
    logic       ovf;
    logic       busy;
    logic       done;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cIn4;
    logic       sub4;
    logic [3:0] s4;
    logic       cOut4;
    logic       ovf4;
    logic       busy4;
    logic       done4;

    int         checkCount;
    int         errorCount;
    logic [7:0] lastS;
    logic       lastC;
    logic       lastOvf;
    logic       sawDone;

    sumador_secuencial #(.N(8), .K(2)) dut8 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(cIn), .sub(sub),
        .s(s), .c_out(cOut), .ovf(ovf), .busy(busy), .done(done)
    );

    sumador_secuencial #(.N(4), .K(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .c_in(cIn4), .sub(sub4),
        .s(s4), .c_out(cOut4), .ovf(ovf4), .busy(busy4), .done(done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Presents one operation for a single rising edge; returns on the falling edge after the capture edge.
    task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB, input logic carry, input logic mode);
        @(negedge clk);
        a     = opA;
        b     = opB;
        cIn   = carry;
        sub   = mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Expects four busy cycles holding the previous result, then one done cycle with the new result.
    task automatic checkOperation(input string tag, input logic [7:0] expS, input logic expC, input logic expOvf);
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            checkOutput({tag, " done low"}, 32'(done), 32'd0);
            checkOutput({tag, " s held"}, 32'(s), 32'(lastS));
            checkOutput({tag, " c_out held"}, 32'(cOut), 32'(lastC));
            @(negedge clk);
        end
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy low"}, 32'(busy), 32'd0);
        checkOutput({tag, " s"}, 32'(s), 32'(expS));
        checkOutput({tag, " c_out"}, 32'(cOut), 32'(expC));
        checkOutput({tag, " ovf"}, 32'(ovf), 32'(expOvf));
        lastS   = expS;
        lastC   = expC;
        lastOvf = expOvf;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        lastS      = 8'h00;
        lastC      = 1'b0;
        lastOvf    = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        a          = 8'h00;
        b          = 8'h00;
        cIn        = 1'b0;
        sub        = 1'b0;
        start4     = 1'b0;
        a4         = 4'h0;
        b4         = 4'h0;
        cIn4       = 1'b0;
        sub4       = 1'b0;

        #1;
        checkOutput("reset s", 32'(s), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset c_out", 32'(cOut), 32'd0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("[TB] 100 + 55");
        applyStimulus(8'd100, 8'd55, 1'b0, 1'b0);
        checkOperation("add100_55", 8'h9B, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("after done idle", 32'(done), 32'd0);
        checkOutput("after done busy", 32'(busy), 32'd0);
        checkOutput("idle s held", 32'(s), 32'h9B);

        $display("[TB] 200 + 100");
        applyStimulus(8'd200, 8'd100, 1'b0, 1'b0);
        checkOperation("add200_100", 8'h2C, 1'b1, 1'b0);

        $display("[TB] 5 - 7 with c_in set");
        applyStimulus(8'd5, 8'd7, 1'b1, 1'b1);
        checkOperation("sub5_7", 8'hFE, 1'b0, 1'b0);

        $display("[TB] back-to-back with start held");
        applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        checkOperation("ff_plus_cin", 8'h00, 1'b1, 1'b0);
        a   = 8'h10;
        b   = 8'h20;
        cIn = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checkOperation("b2b_second", 8'h30, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("b2b idle done", 32'(done), 32'd0);
        checkOutput("b2b idle busy", 32'(busy), 32'd0);

        $display("[TB] reset during second SUMA cycle");
        applyStimulus(8'd100, 8'd55, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort s", 32'(s), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort done", 32'(done), 32'd0);
        checkOutput("abort c_out", 32'(cOut), 32'd0);
        checkOutput("abort ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("no done after abort", 32'(sawDone), 32'd0);
        lastS = 8'h00;
        lastC = 1'b0;
        applyStimulus(8'd200, 8'd100, 1'b0, 1'b0);
        checkOperation("post_reset", 8'h2C, 1'b1, 1'b0);

        $display("[TB] N=4 K=4 single-cycle");
        @(negedge clk);
        a4     = 4'h7;
        b4     = 4'h1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        checkOutput("n4 busy", 32'(busy4), 32'd1);
        checkOutput("n4 done early", 32'(done4), 32'd0);
        @(negedge clk);
        checkOutput("n4 done", 32'(done4), 32'd1);
        checkOutput("n4 s", 32'(s4), 32'h8);
        checkOutput("n4 ovf", 32'(ovf4), 32'd1);
        checkOutput("n4 c_out", 32'(cOut4), 32'd0);
        @(negedge clk);
        checkOutput("n4 idle", 32'(done4), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
